// File: rtl/nor_tt_sequencer_pkg.sv
// Shared state encodings, truth-table constants and helpers for the truth-table sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nor_tt_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Expected z per vector index {x,y}; bit i is the expected output for vector i.
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;

    localparam logic [2:0] ERR_CNT_MAX = 3'd4;

    // Error counter increment that never passes the number of vectors.
    function automatic logic [2:0] err_cnt_inc(input logic [2:0] cnt);
        return (cnt >= ERR_CNT_MAX) ? cnt : cnt + 3'd1;
    endfunction

endpackage

// File: rtl/nor_tt_sequencer_hold_timer.sv
// Hold counter for one test vector; flags the last cycle of each hold window.
// Latency: last is a combinational decode of the registered count (same cycle).
// Backpressure: none; clr has priority over en.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : force the count to zero
//   en       : advance the count; wraps to zero after the terminal value
//   last     : count equals HOLD_CYCLES-1
module hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign last = (cnt == TERM);

    // The count restarts at zero on the terminal edge so it never reaches HOLD_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nor_tt_sequencer.sv
// Truth-table sequencer: steps a 2-input gate through 00,01,10,11 and checks z against EXP_TT.
// Latency: busy for 4*HOLD_CYCLES cycles after the start edge, then a one-cycle done pulse.
// Backpressure: none; start is ignored unless idle, abort cancels a run on the next edge.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, abort    : begin a run (idle only) / cancel a run (wins over start)
//   z               : gate-under-test output, sampled on the last cycle of each hold
//   x, y            : gate inputs, {x,y} = current vector index while busy, else 0
//   busy, done      : vectors being applied / one-cycle completion pulse
//   pass            : last completed run had no mismatches
//   err_cnt         : number of mismatching vectors so far in the current/last run
//   err_mask        : bit i set when vector i mismatched
module nor_tt_sequencer
    import nor_tt_sequencer_pkg::*;
#(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [3:0] EXP_TT      = TT_NOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       z,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] err_mask
);

    state_t     state,        state_nxt;
    logic [1:0] idx,          idx_nxt;
    logic [2:0] err_cnt_nxt;
    logic [3:0] err_mask_nxt;
    logic       pass_nxt;
    logic       hold_last;

    // Count only while vectors are applied; an abort returns the counter to zero with the FSM.
    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state != ST_RUN) || abort),
        .en   (state == ST_RUN),
        .last (hold_last)
    );

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign x    = busy & idx[1];
    assign y    = busy & idx[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            err_cnt  <= 3'd0;
            err_mask <= 4'd0;
            pass     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            err_cnt  <= err_cnt_nxt;
            err_mask <= err_mask_nxt;
            pass     <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        err_cnt_nxt  = err_cnt;
        err_mask_nxt = err_mask;
        pass_nxt     = pass;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt    = ST_RUN;
                    idx_nxt      = 2'd0;
                    err_cnt_nxt  = 3'd0;
                    err_mask_nxt = 4'd0;
                    pass_nxt     = 1'b0;
                end
            end

            ST_RUN: begin
                // The sample on the final hold edge is kept even if abort lands on that edge.
                if (hold_last && (z != EXP_TT[idx])) begin
                    err_mask_nxt[idx] = 1'b1;
                    err_cnt_nxt       = err_cnt_inc(err_cnt);
                end

                if (abort) begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = 2'd0;
                    pass_nxt  = 1'b0;
                end else if (hold_last) begin
                    if (idx == 2'd3) begin
                        state_nxt = ST_DONE;
                        idx_nxt   = 2'd0;
                        pass_nxt  = (err_cnt_nxt == 3'd0);
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nor_tt_sequencer.sv
module tb_nor_tt_sequencer;

    // Instance 0 uses HOLD_CYCLES=4, instance 1 uses HOLD_CYCLES=1.
    logic       clk = 1'b0;
    logic [1:0] rst_s   = 2'b11;
    logic [1:0] start_s = 2'b00;
    logic [1:0] abort_s = 2'b00;
    logic [1:0] z_s;
    logic [1:0] x_s, y_s, busy_s, done_s, pass_s;
    logic [1:0][2:0] cnt_s;
    logic [1:0][3:0] mask_s;
    int mode_s [2];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int       kind;   // 0 complete, 1 aborted, 2 reset mid-run
        int       len;
        int       gap;    // -1 when the idle gap before the run is not checked
        bit       pass;
        int       cnt;
        logic [3:0] mask;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    // Gate under test: mode 0 is the NOR component, other modes model faulty wiring.
    function automatic logic gate(input int mode, input logic a, input logic b);
        case (mode)
            0:       return !(a | b);
            1:       return 1'b0;
            2:       return a | b;
            default: return a & b;
        endcase
    endfunction

    assign z_s[0] = gate(mode_s[0], x_s[0], y_s[0]);
    assign z_s[1] = gate(mode_s[1], x_s[1], y_s[1]);

    nor_tt_sequencer #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .abort(abort_s[0]), .z(z_s[0]),
        .x(x_s[0]), .y(y_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .err_cnt(cnt_s[0]), .err_mask(mask_s[0])
    );

    nor_tt_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .abort(abort_s[1]), .z(z_s[1]),
        .x(x_s[1]), .y(y_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .err_cnt(cnt_s[1]), .err_mask(mask_s[1])
    );

    function automatic int hold_of(input int w);
        return (w == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int w, input exp_t e);
        if (w == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic check_reset_vals(input int w, input string tag);
        check({tag, "_x"},    int'(x_s[w]),    0);
        check({tag, "_y"},    int'(y_s[w]),    0);
        check({tag, "_busy"}, int'(busy_s[w]), 0);
        check({tag, "_done"}, int'(done_s[w]), 0);
        check({tag, "_pass"}, int'(pass_s[w]), 0);
        check({tag, "_cnt"},  int'(cnt_s[w]),  0);
        check({tag, "_mask"}, int'(mask_s[w]), 0);
    endtask

    // Reference: which vectors a gate in this mode gets wrong against the NOR truth table.
    function automatic logic [3:0] fault_mask(input int mode);
        logic [3:0] m;
        logic [1:0] v;
        for (int i = 0; i < 4; i++) begin
            v    = 2'(i);
            m[i] = (gate(mode, v[1], v[0]) != !(v[1] | v[0]));
        end
        return m;
    endfunction

    // Expected outcome of one run; abort_at is the busy cycle (1-based) carrying abort, 0 for none.
    function automatic exp_t make_exp(input int w, input int mode, input int abort_at, input int gap);
        exp_t e;
        logic [3:0] mm;
        int h, n;
        h  = hold_of(w);
        mm = fault_mask(mode);
        e.gap = gap;
        if (abort_at == 0) begin
            e.kind = 0;
            e.len  = 4 * h;
            e.mask = mm;
        end else begin
            n = abort_at / h;
            if (n > 4) n = 4;
            e.kind = 1;
            e.len  = abort_at;
            e.mask = mm & 4'((1 << n) - 1);
        end
        e.cnt  = $countones(e.mask);
        e.pass = (e.kind == 0) && (e.cnt == 0);
        return e;
    endfunction

    task automatic wait_idle(input int w);
        int t;
        t = 0;
        while (busy_s[w] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle_timeout: busy still %0d after %0d cycles", busy_s[w], t);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_run(input int w, input int mode, input int abort_at);
        mode_s[w] = mode;
        push_exp(w, make_exp(w, mode, abort_at, -1));
        start_s[w] = 1'b1;
        @(negedge clk);
        start_s[w] = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            abort_s[w] = 1'b1;
            @(negedge clk);
            abort_s[w] = 1'b0;
        end
        wait_idle(w);
    endtask

    task automatic rand_runs(input int w, input int n);
        int mode, ab, gap;
        for (int r = 0; r < n; r++) begin
            mode = int'($urandom_range(0, 3));
            ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4 * hold_of(w))) : 0;
            gap  = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            do_run(w, mode, ab);
        end
    endtask

    // Monitor: tracks each busy window and compares it with the next queued expectation.
    task automatic mon(input int w);
        bit   pb;
        bit   vok;
        int   len, idle, gap, h;
        exp_t e;
        pb = 0; vok = 1; len = 0; idle = 0; gap = 0;
        h  = hold_of(w);
        forever begin
            @(posedge clk);
            #1;
            if (busy_s[w]) begin
                if (!pb) begin
                    gap = idle;
                    len = 0;
                    vok = 1;
                end
                if (int'({x_s[w], y_s[w]}) != len / h) vok = 0;
                len++;
                idle = 0;
                check("done_while_busy", int'(done_s[w]), 0);
            end else begin
                if (pb) begin
                    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_run_end: dut%0d busy window of %0d cycles with no expectation", w, len);
                    end else begin
                        e = (w == 0) ? q0.pop_front() : q1.pop_front();
                        if (e.kind == 2) begin
                            check("rst_done", int'(done_s[w]), 0);
                            check("rst_pass", int'(pass_s[w]), 0);
                            check("rst_cnt",  int'(cnt_s[w]),  0);
                            check("rst_mask", int'(mask_s[w]), 0);
                        end else begin
                            check("busy_len", len, e.len);
                            check("vectors",  int'(vok), 1);
                            check("done",     int'(done_s[w]), (e.kind == 0) ? 1 : 0);
                            check("pass",     int'(pass_s[w]), int'(e.pass));
                            check("err_cnt",  int'(cnt_s[w]),  e.cnt);
                            check("err_mask", int'(mask_s[w]), int'(e.mask));
                            check("xy_idle",  int'({x_s[w], y_s[w]}), 0);
                            if (e.gap >= 0) check("gap", gap, e.gap);
                        end
                    end
                end else begin
                    check("done_while_idle", int'(done_s[w]), 0);
                end
                idle++;
            end
            pb = busy_s[w];
        end
    endtask

    initial mon(0);
    initial mon(1);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        mode_s[0] = 0;
        mode_s[1] = 0;

        // Reset held three cycles with no start.
        repeat (3) @(negedge clk);
        check_reset_vals(0, "reset4");
        check_reset_vals(1, "reset1");
        rst_s = 2'b00;
        @(negedge clk);
        check_reset_vals(0, "post_reset4");

        // HOLD_CYCLES=4: good run, stuck-at-0, OR-wired, abort in busy cycle 7.
        do_run(0, 0, 0);
        check("pass_held", int'(pass_s[0]), 1);
        do_run(0, 1, 0);
        do_run(0, 2, 0);
        do_run(0, 0, 7);

        // start and abort together while idle: nothing starts.
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        check("start_abort_idle", int'(busy_s[0]), 0);
        @(negedge clk);
        check("start_abort_idle2", int'(busy_s[0]), 0);

        // start held for 40 cycles: three back-to-back runs with a two-cycle gap.
        mode_s[0] = 0;
        push_exp(0, make_exp(0, 0, 0, -1));
        push_exp(0, make_exp(0, 0, 0, 2));
        push_exp(0, make_exp(0, 0, 0, 2));
        start_s[0] = 1'b1;
        repeat (40) @(negedge clk);
        start_s[0] = 1'b0;
        wait_idle(0);

        // Start pulses during a run are ignored.
        push_exp(0, make_exp(0, 0, 0, -1));
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int c = 2; c <= 16; c++) begin
            @(negedge clk);
            start_s[0] = (c == 3 || c == 9 || c == 15);
        end
        start_s[0] = 1'b0;
        wait_idle(0);
        check("no_restart", int'(busy_s[0]), 0);

        rand_runs(0, 12);

        // HOLD_CYCLES=1: good and faulty runs.
        do_run(1, 0, 0);
        do_run(1, 1, 0);
        do_run(1, 2, 0);

        // Asynchronous reset between edges while vector 2 is applied.
        mode_s[1] = 0;
        e.kind = 2; e.len = 0; e.gap = -1; e.pass = 0; e.cnt = 0; e.mask = 4'd0;
        push_exp(1, e);
        start_s[1] = 1'b1;
        @(negedge clk);
        start_s[1] = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("vec2_x", int'(x_s[1]), 1);
        check("vec2_y", int'(y_s[1]), 0);
        rst_s[1] = 1'b1;
        #1;
        check_reset_vals(1, "async_rst");
        @(negedge clk);
        rst_s[1] = 1'b0;
        @(negedge clk);
        check_reset_vals(1, "after_async_rst");

        do_run(1, 0, 0);
        rand_runs(1, 10);

        repeat (5) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
